// File: rtl/tank_game_pkg.sv
// Shared types and constants for the tank game blocks.
package tank_game_pkg;

  localparam int unsigned NUM_TANKS = 4;
  localparam int unsigned TANK_W    = 2;

  localparam logic [7:0] KEY_FIRE = 8'h2C;
  localparam logic [7:0] KEY_Q    = 8'h14;
  localparam logic [7:0] KEY_E    = 8'h08;

  localparam logic [1:0] GS_PLAY = 2'd1;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_AIM    = 3'd1,
    PH_FIRE   = 3'd2,
    PH_FLIGHT = 3'd3,
    PH_NEXT   = 3'd4,
    PH_OVER   = 3'd5
  } turn_phase_t;

endpackage

// File: rtl/rr_next_alive.sv
// Round-robin search over live tanks: next after cur, lowest live index, live count.
module rr_next_alive
  import tank_game_pkg::*;
(
  input  logic [NUM_TANKS-1:0] alive,
  input  logic [TANK_W-1:0]    cur,
  output logic [TANK_W-1:0]    next,
  output logic [TANK_W-1:0]    lowest,
  output logic [2:0]           count
);

  logic [TANK_W-1:0] cand;

  always_comb begin
    next   = cur;
    lowest = '0;
    count  = '0;
    cand   = '0;
    for (int i = int'(NUM_TANKS) - 1; i >= 0; i--) begin
      if (alive[i]) lowest = TANK_W'(i);
    end
    for (int i = 0; i < int'(NUM_TANKS); i++) begin
      count = count + 3'(alive[i]);
    end
    // Walk offsets downward so the nearest live tank after cur wins.
    for (int k = int'(NUM_TANKS) - 1; k >= 1; k--) begin
      cand = cur + TANK_W'(k);
      if (alive[cand]) next = cand;
    end
  end

endmodule

// File: rtl/turn_controller.sv
// Turn scheduler: aim countdown, fire handshake, shot wait and round-robin turn rotation.
module turn_controller
  import tank_game_pkg::*;
#(
  parameter int unsigned TURN_FRAMES = 600,
  parameter int unsigned TIMER_W     = 10
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_tick,
  input  logic [1:0]           game_state,
  input  logic [7:0]           keycode,
  input  logic [NUM_TANKS-1:0] tank_alive,
  input  logic                 fire_ack,
  input  logic                 shot_done,
  output logic [TANK_W-1:0]    active_tank,
  output logic                 fire_req,
  output logic [2:0]           turn_phase,
  output logic [TIMER_W-1:0]   time_left,
  output logic                 game_over,
  output logic [TANK_W-1:0]    winner
);

  turn_phase_t         state, state_nx;
  logic [TANK_W-1:0]   active_tank_nx, winner_nx;
  logic [TIMER_W-1:0]  time_left_nx;
  logic                fire_req_nx, game_over_nx;
  logic                fire_armed, fire_armed_nx;

  logic [TANK_W-1:0]   rr_next, rr_lowest;
  logic [2:0]          rr_count;
  logic                playing, fire_press, few_left;
  logic [TANK_W-1:0]   sole_tank;

  rr_next_alive u_rr (
    .alive  (tank_alive),
    .cur    (active_tank),
    .next   (rr_next),
    .lowest (rr_lowest),
    .count  (rr_count)
  );

  assign playing    = (game_state == GS_PLAY);
  assign fire_press = (keycode == KEY_FIRE) && fire_armed;
  assign few_left   = (rr_count <= 3'd1);
  // A draw (nobody alive) reports tank 0 as winner.
  assign sole_tank  = (rr_count == 3'd1) ? rr_lowest : '0;
  assign turn_phase = state;

  // State and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= PH_IDLE;
      active_tank <= '0;
      fire_req    <= 1'b0;
      time_left   <= '0;
      game_over   <= 1'b0;
      winner      <= '0;
      fire_armed  <= 1'b0;
    end else begin
      state       <= state_nx;
      active_tank <= active_tank_nx;
      fire_req    <= fire_req_nx;
      time_left   <= time_left_nx;
      game_over   <= game_over_nx;
      winner      <= winner_nx;
      fire_armed  <= fire_armed_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx       = state;
    active_tank_nx = active_tank;
    time_left_nx   = time_left;
    game_over_nx   = game_over;
    winner_nx      = winner;
    // Releasing the key re-arms; any sighting of the fire key consumes the arm.
    fire_armed_nx  = (keycode != KEY_FIRE);

    if (state != PH_IDLE && !playing) begin
      state_nx     = PH_IDLE;
      game_over_nx = 1'b0;
      winner_nx    = '0;
    end else begin
      unique case (state)
        PH_IDLE: begin
          if (playing) begin
            if (few_left) begin
              state_nx     = PH_OVER;
              game_over_nx = 1'b1;
              winner_nx    = sole_tank;
            end else begin
              state_nx       = PH_AIM;
              active_tank_nx = rr_lowest;
              time_left_nx   = TIMER_W'(TURN_FRAMES);
            end
          end
        end
        PH_AIM: begin
          if (!tank_alive[active_tank]) begin
            state_nx = PH_NEXT;
          end else if (fire_press) begin
            state_nx = PH_FIRE;
          end else if (frame_tick) begin
            if (time_left <= TIMER_W'(1)) begin
              time_left_nx = '0;
              state_nx     = PH_NEXT;
            end else begin
              time_left_nx = time_left - TIMER_W'(1);
            end
          end
        end
        PH_FIRE: begin
          if (fire_ack) state_nx = shot_done ? PH_NEXT : PH_FLIGHT;
        end
        PH_FLIGHT: begin
          if (shot_done) state_nx = PH_NEXT;
        end
        PH_NEXT: begin
          if (few_left) begin
            state_nx     = PH_OVER;
            game_over_nx = 1'b1;
            winner_nx    = sole_tank;
          end else begin
            state_nx       = PH_AIM;
            active_tank_nx = rr_next;
            time_left_nx   = TIMER_W'(TURN_FRAMES);
          end
        end
        PH_OVER: begin
          game_over_nx = 1'b1;
          winner_nx    = sole_tank;
        end
        default: state_nx = PH_IDLE;
      endcase
    end

    fire_req_nx = (state_nx == PH_FIRE);
  end

endmodule
